// File: rtl/lut_m_prog_if.sv
// Bus bundle for lut_m_prog: table write port and RD_CH lookup channels.
// The miss_cnt signal exists only when LUT_M_STATS_EN is defined.
interface lut_m_prog_if #(
    parameter int PTR_W = 8,
    parameter int ADR_W = 8,
    parameter int DEPTH = 8,
    parameter int RD_CH = 2
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic [ADR_W-1:0]       wr_data;
    logic [RD_CH-1:0]       rd_req;
    logic [RD_CH*PTR_W-1:0] ptr;
    logic [RD_CH*ADR_W-1:0] dm_adr;
    logic [RD_CH-1:0]       rd_vld;
    logic [RD_CH-1:0]       hit;
    logic                   init_busy;
`ifdef LUT_M_STATS_EN
    logic [15:0]            miss_cnt;

    modport master (output wr_en, wr_idx, wr_data, rd_req, ptr,
                    input  dm_adr, rd_vld, hit, init_busy, miss_cnt);
    modport slave  (input  wr_en, wr_idx, wr_data, rd_req, ptr,
                    output dm_adr, rd_vld, hit, init_busy, miss_cnt);
`else
    modport master (output wr_en, wr_idx, wr_data, rd_req, ptr,
                    input  dm_adr, rd_vld, hit, init_busy);
    modport slave  (input  wr_en, wr_idx, wr_data, rd_req, ptr,
                    output dm_adr, rd_vld, hit, init_busy);
`endif
endinterface

// File: rtl/lut_m_prog.sv
// Programmable multi-channel pointer -> data-memory address lookup table.
// Optional saturating miss counter enabled by defining LUT_M_STATS_EN.
module lut_m_prog #(
    parameter int PTR_W = 8,
    parameter int ADR_W = 8,
    parameter int DEPTH = 8,
    parameter int RD_CH = 2
) (
    input  logic         CLK,
    input  logic         Reset_n,
    lut_m_prog_if.slave  bus,
    output logic         o_dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);
    localparam logic [IDX_W:0] DEPTH_I = (IDX_W+1)'(DEPTH);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_fill_idx;
    logic                   r_init_busy;
    logic [ADR_W-1:0]       r_table [DEPTH];
    logic [RD_CH-1:0]       r_rd_vld;
    logic [RD_CH-1:0]       r_hit;
    logic [RD_CH*ADR_W-1:0] r_dm_adr;

    logic                   w_run;
    logic [ADR_W-1:0]       w_fill_val;
    logic [RD_CH-1:0]       w_hit;
    logic [RD_CH*ADR_W-1:0] w_res;

    assign w_run      = (r_state == ST_RUN);
    assign w_fill_val = ADR_W'(32'(r_fill_idx) + 32'd1);

    // Lookup protocol: a channel request is accepted in any RUN cycle with
    // rd_req[c]=1 (no back-pressure); rd_vld[c] pulses for exactly one cycle
    // on the following cycle with dm_adr/hit, which otherwise hold.
    genvar c;
    for (c = 0; c < RD_CH; c++) begin : g_ch
        logic [PTR_W-1:0] w_ptr;
        logic [IDX_W-1:0] w_idx;
        logic             w_in;
        logic             w_byp;

        assign w_ptr = bus.ptr[c*PTR_W +: PTR_W];
        assign w_idx = w_ptr[IDX_W-1:0];
        assign w_in  = ({1'b0, w_ptr} < DEPTH_P);
        // Write-first: a same-cycle write to the looked-up entry is forwarded.
        assign w_byp = bus.wr_en && w_run && (bus.wr_idx == w_idx);
        assign w_hit[c] = w_in;
        assign w_res[c*ADR_W +: ADR_W] = !w_in ? ADR_W'(w_ptr) :
                                         w_byp ? bus.wr_data : r_table[w_idx];
    end

    always_ff @(posedge CLK) begin
        if (!w_run) begin
            r_table[r_fill_idx] <= w_fill_val;
        end else if (bus.wr_en && ({1'b0, bus.wr_idx} < DEPTH_I)) begin
            r_table[bus.wr_idx] <= bus.wr_data;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_INIT;
            r_fill_idx  <= '0;
            r_init_busy <= 1'b1;
            r_rd_vld    <= '0;
            r_hit       <= '0;
            r_dm_adr    <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rd_vld   <= '0;
                    r_fill_idx <= r_fill_idx + 1'b1;
                    if (r_fill_idx == IDX_W'(DEPTH-1)) begin
                        r_state     <= ST_RUN;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_rd_vld <= bus.rd_req;
                    for (int i = 0; i < RD_CH; i++) begin
                        if (bus.rd_req[i]) begin
                            r_dm_adr[i*ADR_W +: ADR_W] <= w_res[i*ADR_W +: ADR_W];
                            r_hit[i]                   <= w_hit[i];
                        end
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

`ifdef LUT_M_STATS_EN
    logic [15:0] r_miss_cnt;
    logic [16:0] w_miss_sum;

    always_comb begin
        w_miss_sum = {1'b0, r_miss_cnt};
        for (int i = 0; i < RD_CH; i++) begin
            if (bus.rd_req[i] && !w_hit[i]) w_miss_sum = w_miss_sum + 17'd1;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_miss_cnt <= '0;
        end else if (w_run) begin
            r_miss_cnt <= w_miss_sum[16] ? 16'hFFFF : w_miss_sum[15:0];
        end
    end

    assign bus.miss_cnt = r_miss_cnt;
`endif

    assign bus.dm_adr    = r_dm_adr;
    assign bus.rd_vld    = r_rd_vld;
    assign bus.hit       = r_hit;
    assign bus.init_busy = r_init_busy;
    assign o_dbg_state   = r_state;
endmodule
